// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  // Reduction term for the AES field polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // Multiply by {02} in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Single-column forward MixColumns: multiplies one column by the {02,03,01,01} circulant.
// Latency: purely combinational.
// Backpressure: none; the caller owns all sequencing.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col,
  output logic [AES_COL_W-1:0] mixed
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;
  logic [7:0] r0, r1, r2, r3;

  // Row 0 sits in the most significant byte of the column
  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // {03}b is formed as xtime(b) ^ b
  assign r0 = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign r1 = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign r2 = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign r3 = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

  assign mixed = {r0, r1, r2, r3};

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential forward MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency: input handshake to out_valid is 4/COLS_PER_CYCLE cycles; one state in flight at a time.
// Backpressure: result is held in the work register while out_ready=0; in_ready stays low until it drains.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_t              state;
  mc_state_t              state_nxt;
  logic [1:0]             col_cnt;
  logic [AES_STATE_W-1:0] work;
  logic                   last_grp;

  logic [1:0]           col_idx [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] col_out [COLS_PER_CYCLE];

  // The group starting at column 4-COLS_PER_CYCLE is the final one
  assign last_grp = (col_cnt == 2'(4 - COLS_PER_CYCLE));

  // Column c lives at bits [127-32c -: 32], i.e. base offset 32*(3-c) = {~c, 5'b0}
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    assign col_idx[g] = col_cnt + 2'(g);
    assign col_in[g]  = work[{~col_idx[g], 5'b0} +: AES_COL_W];

    mix_column_unit u_mix (
      .col   (col_in[g]),
      .mixed (col_out[g])
    );
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Work register and column counter: load in IDLE, mix one group per cycle in BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      work    <= '0;
      col_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          // Only capture on a real handshake so an undriven bus never reaches the register
          if (in_valid) begin
            work    <= in_state;
            col_cnt <= 2'd0;
          end
        end
        BUSY: begin
          for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            work[{~col_idx[i], 5'b0} +: AES_COL_W] <= col_out[i];
          end
          col_cnt <= col_cnt + 2'(COLS_PER_CYCLE);
        end
        default: begin
          work    <= work;
          col_cnt <= col_cnt;
        end
      endcase
    end
  end

  // Next-state and handshake outputs; everything forced low while rst is asserted
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_state = '0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_grp) state_nxt = DONE;
      end
      DONE: begin
        out_valid = !rst;
        out_state = rst ? '0 : work;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: known vectors, latency per width, backpressure, reset, random.
// Latency: measured against 4/COLS_PER_CYCLE for widths 1, 2 and 4.
// Backpressure: exercised with out_ready held low and randomly toggled.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_state, out_state;
  logic         in_valid2, in_ready2, out_valid2;
  logic [127:0] out_state2;
  logic         in_valid4, in_ready4, out_valid4;
  logic [127:0] out_state4;

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_q[$];
  logic [127:0] src_q[$];

  logic [7:0] mul9  [256];
  logic [7:0] mul11 [256];
  logic [7:0] mul13 [256];
  logic [7:0] mul14 [256];

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
  );
  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_state(in_state),
    .out_valid(out_valid2), .out_ready(out_ready), .out_state(out_state2)
  );
  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_state(in_state),
    .out_valid(out_valid4), .out_ready(out_ready), .out_state(out_state4)
  );

  // Generic shift-and-add GF(2^8) multiply, reduced by 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3,
                           a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3,
                           a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3),
                           gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {mul14[a0] ^ mul11[a1] ^ mul13[a2] ^ mul9[a3],
                           mul9[a0]  ^ mul14[a1] ^ mul11[a2] ^ mul13[a3],
                           mul13[a0] ^ mul9[a1]  ^ mul14[a2] ^ mul11[a3],
                           mul11[a0] ^ mul13[a1] ^ mul9[a2]  ^ mul14[a3]};
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: sample handshakes and output data at the negedge, return at posedge+1
  task automatic tick(output bit ihs, output bit ohs, output logic [127:0] ostate);
    @(negedge clk);
    ihs    = in_valid && in_ready;
    ohs    = out_valid && out_ready;
    ostate = out_state;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit ihs, ohs;
    logic [127:0] os;
    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; in_valid4 = 1'b0;
    out_ready = 1'b0; in_state = '0;
    tick(ihs, ohs, os);
    tick(ihs, ohs, os);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state: got %h want 0", out_state); end
    rst = 1'b0;
    tick(ihs, ohs, os);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    in_state = 'x;
    repeat (3) tick(ihs, ohs, os);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_x_out_valid: got %b want 0", out_valid); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL idle_x_out_state: got %h want 0", out_state); end
    in_state = '0;
  endtask

  task automatic test_fips();
    bit ihs, ohs, done;
    logic [127:0] os, e;
    done = 1'b0;
    in_state = V1_IN; in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 30 && !done; n++) begin
      tick(ihs, ohs, os);
      if (ihs) begin exp_q.push_back(V1_OUT); in_valid = 1'b0; end
      if (ohs) begin
        e = exp_q.pop_front();
        checks++; if (os !== e) begin errors++; $display("FAIL fips_state: got %h want %h", os, e); end
        done = 1'b1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL fips_timeout: got no output want one"); end
  endtask

  task automatic test_latency();
    int hs1, hs2, hs4, ov1, ov2, ov4;
    logic [127:0] os1, os2, os4;
    hs1 = -1; hs2 = -1; hs4 = -1; ov1 = -1; ov2 = -1; ov4 = -1;
    os1 = '0; os2 = '0; os4 = '0;
    in_state = V2_IN; out_ready = 1'b1;
    in_valid = 1'b1; in_valid2 = 1'b1; in_valid4 = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (in_valid && in_ready && hs1 < 0) hs1 = n;
      if (in_valid2 && in_ready2 && hs2 < 0) hs2 = n;
      if (in_valid4 && in_ready4 && hs4 < 0) hs4 = n;
      if (out_valid && ov1 < 0) begin ov1 = n; os1 = out_state; end
      if (out_valid2 && ov2 < 0) begin ov2 = n; os2 = out_state2; end
      if (out_valid4 && ov4 < 0) begin ov4 = n; os4 = out_state4; end
      @(posedge clk);
      #1;
      if (hs1 >= 0) in_valid = 1'b0;
      if (hs2 >= 0) in_valid2 = 1'b0;
      if (hs4 >= 0) in_valid4 = 1'b0;
    end
    // out_valid first seen at negedge n means it rose at the posedge before, so subtract one
    checks++; if (ov1 - hs1 - 1 !== 4 || hs1 < 0) begin errors++; $display("FAIL latency_c1: got %0d want 4", ov1 - hs1 - 1); end
    checks++; if (ov2 - hs2 - 1 !== 2 || hs2 < 0) begin errors++; $display("FAIL latency_c2: got %0d want 2", ov2 - hs2 - 1); end
    checks++; if (ov4 - hs4 - 1 !== 1 || hs4 < 0) begin errors++; $display("FAIL latency_c4: got %0d want 1", ov4 - hs4 - 1); end
    checks++; if (os1 !== V2_OUT) begin errors++; $display("FAIL v2_state_c1: got %h want %h", os1, V2_OUT); end
    checks++; if (os2 !== V2_OUT) begin errors++; $display("FAIL v2_state_c2: got %h want %h", os2, V2_OUT); end
    checks++; if (os4 !== V2_OUT) begin errors++; $display("FAIL v2_state_c4: got %h want %h", os4, V2_OUT); end
  endtask

  task automatic test_backpressure();
    bit ihs, ohs, seen;
    logic [127:0] os, s, e;
    s = rnd128();
    e = mix_ref(s);
    seen = 1'b0;
    out_ready = 1'b0; in_state = s; in_valid = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick(ihs, ohs, os);
      if (ihs) begin in_valid = 1'b0; in_state = rnd128(); end
      if (out_valid) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_timeout: got no out_valid want 1"); end
    for (int n = 0; n < 10; n++) begin
      checks++; if (out_state !== e || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_state: got %h want %h", out_state, e); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      tick(ihs, ohs, os);
    end
    out_ready = 1'b1;
    tick(ihs, ohs, os);
    checks++; if (!ohs || os !== e) begin errors++; $display("FAIL bp_accept: got hs=%b %h want hs=1 %h", ohs, os, e); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_after: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    bit ihs, ohs;
    logic [127:0] os, e;
    int sent, got, t0, t1;
    sent = 0; got = 0; t0 = -1; t1 = -1;
    in_state = V1_IN; in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 40 && got < 2; n++) begin
      tick(ihs, ohs, os);
      if (ihs) begin
        exp_q.push_back(sent == 0 ? V1_OUT : V2_OUT);
        if (sent == 0) begin t0 = n; in_state = V2_IN; end
        else begin t1 = n; in_valid = 1'b0; end
        sent++;
      end
      if (ohs) begin
        e = exp_q.pop_front();
        checks++; if (os !== e) begin errors++; $display("FAIL b2b_state%0d: got %h want %h", got, os, e); end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", got); end
    checks++; if (t1 - t0 < 6) begin errors++; $display("FAIL b2b_gap: got %0d want >=6", t1 - t0); end
  endtask

  task automatic test_reset_mid();
    bit ihs, ohs, acc, saw;
    logic [127:0] os;
    acc = 1'b0; saw = 1'b0;
    in_state = rnd128(); in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 10 && !acc; n++) begin
      tick(ihs, ohs, os);
      if (ihs) acc = 1'b1;
    end
    in_valid = 1'b0;
    checks++; if (!acc) begin errors++; $display("FAIL rstmid_accept: got no handshake want one"); end
    tick(ihs, ohs, os);
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready_rst: got %b want 0", in_ready); end
    tick(ihs, ohs, os);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0 || out_state !== 128'h0) begin errors++; $display("FAIL rstmid_outputs: got %b %h want 0 0", out_valid, out_state); end
    for (int n = 0; n < 8; n++) begin
      tick(ihs, ohs, os);
      if (out_valid || ohs) saw = 1'b1;
    end
    checks++; if (saw) begin errors++; $display("FAIL rstmid_no_output: got out_valid=1 want 0"); end
  endtask

  task automatic test_random();
    bit ihs, ohs;
    logic [127:0] os, e, s;
    int sent, got;
    const int N = 10000;
    sent = 0; got = 0;
    in_state = rnd128(); in_valid = 1'b1;
    for (int n = 0; n < 75000 && got < N; n++) begin
      out_ready = ($urandom_range(0, 7) != 0);
      tick(ihs, ohs, os);
      if (ihs) begin
        src_q.push_back(in_state);
        exp_q.push_back(mix_ref(in_state));
        sent++;
        if (sent < N) in_state = rnd128();
        else in_valid = 1'b0;
      end
      if (ohs) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_spurious: got output want none");
        end else begin
          e = exp_q.pop_front();
          s = src_q.pop_front();
          checks++; if (os !== e) begin errors++; $display("FAIL rand_state%0d: got %h want %h", got, os, e); end
          checks++; if (inv_mix(os) !== s) begin errors++; $display("FAIL rand_inverse%0d: got %h want %h", got, inv_mix(os), s); end
        end
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != N) begin errors++; $display("FAIL rand_count: got %0d want %0d", got, N); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mul9[i]  = gmul(8'(i), 8'h09);
      mul11[i] = gmul(8'(i), 8'h0b);
      mul13[i] = gmul(8'(i), 8'h0d);
      mul14[i] = gmul(8'(i), 8'h0e);
    end
    test_reset();
    test_fips();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
